// File: rtl/fp_pkg.sv
// Shared fp32 constants, FSM/class enums and operand classification helper.
package fp_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = FRAC_W + 1;
  localparam int unsigned REM_W   = MANT_W + 1;
  localparam int unsigned QUO_W   = MANT_W + 2;
  localparam int unsigned EXPC_W  = 10;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned BIAS    = 127;

  localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // Denormals (exponent 0) are classified as zero.
  function automatic fp_class_e classify(input logic [FP_W-1:0] x);
    fp_class_e cls;
    if (x[FP_W-2 -: EXP_W] == '0) begin
      cls = ZERO;
    end else if (x[FP_W-2 -: EXP_W] == '1) begin
      cls = (x[FRAC_W-1:0] == '0) ? INF : NAN;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/sub_25bits.sv
// 25-bit ripple subtractor: a - b as a + ~b + 1; carry_out high means a >= b.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module sub_25bits (
  input  logic [24:0] a,
  input  logic [24:0] b,
  output logic [24:0] diff,
  output logic        carry_out
);

  logic [25:0] carry;

  assign carry[0]  = 1'b1;
  assign carry_out = carry[25];

  // Ripple chain of full-adder cells over the inverted subtrahend.
  for (genvar i = 0; i < 25; i++) begin : g_bit
    fa_cell u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (carry[i]),
      .s  (diff[i]),
      .co (carry[i+1])
    );
  end

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential fp32 divider: 26-step restoring mantissa division, RNE rounding.
module fp32_div_seq
  import fp_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [FP_W-1:0]   i_data_one,
  input  logic [FP_W-1:0]   i_data_two,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [FP_W-1:0]   o_data,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_div_by_zero,
  output logic              o_invalid
);

  div_state_e               state_q, state_nxt;
  logic [CNT_W-1:0]         cnt_q;
  logic                     sign_q;
  logic signed [EXPC_W-1:0] exp_q;
  logic [MANT_W-1:0]        mb_q;
  logic [REM_W-1:0]         rem_q;
  logic [QUO_W-1:0]         quo_q;
  logic                     spec_q, spec_inv_q, spec_dbz_q;
  logic [FP_W-1:0]          spec_data_q;

  logic                     accept_c;
  logic                     ready_nxt, valid_nxt;

  // Acceptance-time special-case decode.
  fp_class_e                cls_a, cls_b;
  logic                     sign_c;
  logic                     spec_c, spec_inv_c, spec_dbz_c;
  logic [FP_W-1:0]          spec_data_c;

  // Subtractor shared by every DIV iteration.
  logic [REM_W-1:0]         sub_diff;
  logic                     sub_ge;
  logic [REM_W-1:0]         rem_sel;

  // Rounding datapath.
  logic [MANT_W-1:0]        norm_mant;
  logic                     guard, sticky, round_up;
  logic signed [EXPC_W-1:0] norm_exp, rnd_exp;
  logic [MANT_W:0]          mant_inc;
  logic [FRAC_W-1:0]        rnd_frac;
  logic [FP_W-1:0]          res_data;
  logic                     res_ovf, res_unf;

  assign accept_c = (state_q == IDLE) && i_valid;

  sub_25bits u_sub (
    .a         (rem_q),
    .b         ({1'b0, mb_q}),
    .diff      (sub_diff),
    .carry_out (sub_ge)
  );

  assign rem_sel = sub_ge ? sub_diff : rem_q;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_nxt = DIV;
      DIV:     if (cnt_q == CNT_W'(QUO_W - 1)) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs follow the upcoming state so they are registered.
  always_comb begin
    ready_nxt = 1'b0;
    valid_nxt = 1'b0;
    if (state_nxt == IDLE) ready_nxt = 1'b1;
    if (state_nxt == DONE) valid_nxt = 1'b1;
  end

  // Special-case decode of the incoming operand pair.
  always_comb begin
    cls_a       = classify(i_data_one);
    cls_b       = classify(i_data_two);
    sign_c      = i_data_one[FP_W-1] ^ i_data_two[FP_W-1];
    spec_c      = 1'b1;
    spec_inv_c  = 1'b0;
    spec_dbz_c  = 1'b0;
    spec_data_c = {sign_c, {(FP_W-1){1'b0}}};
    if (cls_a == NAN || cls_b == NAN ||
        (cls_a == ZERO && cls_b == ZERO) ||
        (cls_a == INF  && cls_b == INF)) begin
      spec_data_c = QNAN;
      spec_inv_c  = 1'b1;
    end else if (cls_a == INF) begin
      spec_data_c = {sign_c, POS_INF[FP_W-2:0]};
    end else if (cls_b == ZERO) begin
      spec_data_c = {sign_c, POS_INF[FP_W-2:0]};
      spec_dbz_c  = 1'b1;
    end else if (cls_b == INF || cls_a == ZERO) begin
      spec_data_c = {sign_c, {(FP_W-1){1'b0}}};
    end else begin
      spec_c = 1'b0;
    end
  end

  // Normalize, round to nearest-even, range-check, apply special override.
  always_comb begin
    norm_mant = quo_q[QUO_W-1] ? quo_q[QUO_W-1:2] : quo_q[QUO_W-2:1];
    guard     = quo_q[QUO_W-1] ? quo_q[1] : quo_q[0];
    sticky    = (quo_q[QUO_W-1] & quo_q[0]) | (rem_q != '0);
    norm_exp  = quo_q[QUO_W-1] ? exp_q : exp_q - 10'sd1;
    round_up  = guard & (sticky | norm_mant[0]);
    mant_inc  = {1'b0, norm_mant} + (MANT_W+1)'(round_up);
    // A carry-out leaves 1.0 in the upper bits; shifting right renormalizes.
    rnd_frac  = mant_inc[MANT_W] ? mant_inc[MANT_W-1:1] : mant_inc[FRAC_W-1:0];
    rnd_exp   = norm_exp + EXPC_W'(mant_inc[MANT_W]);
    res_ovf   = 1'b0;
    res_unf   = 1'b0;
    res_data  = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
    if (spec_q) begin
      res_data = spec_data_q;
    end else if (rnd_exp >= 10'sd255) begin
      res_data = {sign_q, POS_INF[FP_W-2:0]};
      res_ovf  = 1'b1;
    end else if (rnd_exp <= 10'sd0) begin
      res_data = {sign_q, {(FP_W-1){1'b0}}};
      res_unf  = 1'b1;
    end
  end

  // Operand capture and restoring-division iterations.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mb_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      spec_q      <= 1'b0;
      spec_inv_q  <= 1'b0;
      spec_dbz_q  <= 1'b0;
      spec_data_q <= '0;
    end else if (accept_c) begin
      cnt_q       <= '0;
      sign_q      <= sign_c;
      exp_q       <= $signed({2'b00, i_data_one[FP_W-2 -: EXP_W]})
                   - $signed({2'b00, i_data_two[FP_W-2 -: EXP_W]})
                   + $signed(EXPC_W'(BIAS));
      mb_q        <= {1'b1, i_data_two[FRAC_W-1:0]};
      rem_q       <= {2'b01, i_data_one[FRAC_W-1:0]};
      quo_q       <= '0;
      spec_q      <= spec_c;
      spec_inv_q  <= spec_inv_c;
      spec_dbz_q  <= spec_dbz_c;
      spec_data_q <= spec_data_c;
    end else if (state_q == DIV) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= rem_sel << 1;
      quo_q <= {quo_q[QUO_W-2:0], sub_ge};
    end
  end

  // Registered result, flags and handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready       <= 1'b1;
      o_valid       <= 1'b0;
      o_data        <= '0;
      o_overflow    <= 1'b0;
      o_underflow   <= 1'b0;
      o_div_by_zero <= 1'b0;
      o_invalid     <= 1'b0;
    end else begin
      o_ready <= ready_nxt;
      o_valid <= valid_nxt;
      if (state_q == ROUND) begin
        o_data        <= res_data;
        o_overflow    <= res_ovf;
        o_underflow   <= res_unf;
        o_div_by_zero <= spec_dbz_q;
        o_invalid     <= spec_inv_q;
      end
    end
  end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed-vector bench for fp32_div_seq: results, flags, latency, handshake, reset abort.
module tb_fp32_div_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data_one;
  logic [31:0] i_data_two;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_overflow, o_underflow, o_div_by_zero, o_invalid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  f;   // {overflow, underflow, div_by_zero, invalid}
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  fp32_div_seq dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_data_one    (i_data_one),
    .i_data_two    (i_data_two),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow),
    .o_div_by_zero (o_div_by_zero),
    .o_invalid     (o_invalid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {o_overflow, o_underflow, o_div_by_zero, o_invalid};
  endfunction

  // Issue one operation, measure latency, optionally stall the result, then consume.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [3:0] exp_f,
                        input string name, input int hold);
    int lat;
    lat = 0;
    while (o_ready !== 1'b1 && lat < 50) begin
      @(posedge i_clk); #1; lat++;
    end
    check({name, " ready_before"}, 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_valid    = 1'b1;
    i_data_one = a;
    i_data_two = b;
    @(posedge i_clk); #1;
    i_valid    = 1'b0;
    i_data_one = 32'hDEAD_BEEF;
    i_data_two = 32'h1234_5678;
    check({name, " ready_busy"}, 32'(o_ready), 32'd0);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      @(posedge i_clk); #1; lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd27);
    check({name, " data"}, o_data, exp_q);
    check({name, " flags"}, 32'(flags()), 32'(exp_f));
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      i_valid    = (i % 2 == 0);
      i_data_one = 32'h3F80_0000;
      i_data_two = 32'h3F80_0000;
      @(posedge i_clk); #1;
      check({name, " hold_data"}, o_data, exp_q);
      check({name, " hold_hs"}, {30'd0, o_valid, o_ready}, {30'd0, 1'b1, 1'b0});
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check({name, " consumed"}, {30'd0, o_valid, o_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    int seen_valid;

    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000}; // 6/2
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000}; // 1/3 round up
    vecs[2]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0010}; // 1/0
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001}; // 0/0
    vecs[4]  = '{32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b1000}; // overflow
    vecs[5]  = '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0100}; // underflow
    vecs[6]  = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0000}; // inf/2
    vecs[7]  = '{32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000}; // 2/-inf
    vecs[8]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b0001}; // NaN/1
    vecs[9]  = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b0001}; // inf/inf
    vecs[10] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000}; // 1/1
    vecs[11] = '{32'h3FC0_0000, 32'h3F80_0000, 32'h3FC0_0000, 4'b0000}; // 1.5/1
    vecs[12] = '{32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 4'b0000}; // 0/-2
    vecs[13] = '{32'hC0C0_0000, 32'hC000_0000, 32'h4040_0000, 4'b0000}; // -6/-2
    vecs[14] = '{32'h3F80_0000, 32'hC040_0000, 32'hBEAA_AAAB, 4'b0000}; // 1/-3
    vecs[15] = '{32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 4'b0000}; // 2/3

    i_rst_n    = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b0;
    i_data_one = '0;
    i_data_two = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_hs", {30'd0, o_valid, o_ready}, {30'd0, 1'b0, 1'b1});
    check("reset_data", o_data, 32'h0);
    check("reset_flags", 32'(flags()), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f, $sformatf("vec%0d", i), 0);
    end

    // Backpressure: result held for 10 cycles while i_valid pulses are ignored.
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, "stall", 10);
    // Issue interval right after consume still gives a clean result.
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, "after_stall", 0);

    // Reset in the middle of DIV aborts the operation.
    @(negedge i_clk);
    i_valid    = 1'b1;
    i_data_one = 32'h40C0_0000;
    i_data_two = 32'h4000_0000;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (12) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("abort_during_reset", {30'd0, o_valid, o_ready}, {30'd0, 1'b0, 1'b1});
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge i_clk); #1;
      if (o_valid === 1'b1 || o_ready !== 1'b1) seen_valid = 1;
    end
    check("abort_no_result", 32'(seen_valid), 32'd0);
    check("abort_data", o_data, 32'h0);
    run_op(32'hC100_0000, 32'h4000_0000, 32'hC080_0000, 4'b0000, "post_reset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
